msg_out_buffer: RTL and testbench
=================================

// Module: msg_out_buffer
// PURPOSE
//  Downstream stage of the message parser. Absorbs parsed messages (256b data + 32b bytemask, no backpressure upstream).
//  Buffers them in a small FIFO and re-issues them on a valid/ready interface with a byte-length field.
//  Drops and counts messages when full; the parser output cannot be stalled.
// PARAMETERS
//  OP_DATA_WIDTH  256              message data width, bits (multiple of 8)
//  OP_BM_WIDTH    OP_DATA_WIDTH/8  bytemask width
//  DEPTH          4                FIFO entries (power of 2, >=2)
//  CNT_WIDTH      16               drop counter width
// PORTS
//  clk            in   1                  clock, all logic on posedge
//  reset          in   1                  asynchronous, active-high reset
//  in_valid       in   1                  parser message strobe, one message per cycle
//  in_data        in   OP_DATA_WIDTH      message; byte j = in_data[8*j+:8], byte 0 first
//  in_bytemask    in   OP_BM_WIDTH        bit j = byte j valid
//  out_valid      out  1                  message available
//  out_ready      in   1                  consumer accepts when out_valid&&out_ready
//  out_data       out  OP_DATA_WIDTH      head message data
//  out_bytemask   out  OP_BM_WIDTH        head message mask
//  out_len        out  $clog2(OP_BM_WIDTH)+1  popcount(out_bytemask), 0..32
//  fill_level     out  $clog2(DEPTH)+1    entries held, 0..DEPTH
//  overflow       out  1                  sticky: a message was dropped
//  drop_count     out  CNT_WIDTH          saturating count of dropped messages
//  clear_stats    in   1                  sync pulse: clears overflow and drop_count
// BEHAVIOUR
//  Reset: FIFO empty; out_valid=0, out_data/out_bytemask/out_len=0, fill_level=0, overflow=0, drop_count=0.
//  Push: in_valid && in_bytemask!=0 && (not full || pop this cycle). Zero-mask strobe is ignored, not a drop.
//  Pop: out_valid && out_ready. Push+pop in the same cycle: both occur and fill_level is unchanged (also when full).
//  Drop: push requested while full without pop. Entry is discarded, overflow<=1, drop_count+1 saturating at all-ones.
//  Drop and clear_stats in the same cycle: clear wins, then the count is 1 and overflow is 1.
//  Latency: a push into an empty FIFO gives out_valid on the next cycle (registered output, FWFT).
//  Head stability: out_data/out_bytemask/out_len hold while out_valid && !out_ready.
//  out_len is computed at push and stored with the entry, not recomputed on the output path.
//  Non-contiguous masks are passed unchanged; out_len is still the popcount.
//  Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. full = (fill_level==DEPTH). empty = (fill_level==0).
//  Output regs: out_data/out_bytemask/out_len <=0 when FIFO becomes empty; out_valid deasserts on the same edge.
//  Reset mid-operation: all contents discarded immediately (async); no partial message is emitted afterwards.
//  FSM (head register) states:
//   EMPTY: out_valid=0. Go to HOLD on push.
//   HOLD: out_valid=1. On pop, stay in HOLD if the FIFO is non-empty after the pop (head reloads next entry);
//         otherwise go to EMPTY. A push in the same cycle keeps HOLD.
// STRUCTURE
//  Package parser_pkg: OP_DATA_WIDTH, OP_BM_WIDTH constants, msg_t struct {data, bytemask, len},
//  and function automatic popcount(bytemask) shared with the parser.
//  Sub-module msg_sync_fifo holds the storage RAM, pointers and fill count, with a same-cycle push/pop contract.
//  msg_out_buffer adds drop logic, stats, popcount and the head register.
// TESTING
//  1. Single push, mask=32'h0000_00FF, data bytes 0..7 = 8'h01..8'h08, out_ready=1
//     -> next cycle out_valid=1, out_len=8, bytes match; then empty, fill_level=0.
//  2. out_ready=0, push 5 messages back-to-back (DEPTH=4)
//     -> fill_level=4, overflow=1, drop_count=1; drain gives msgs 1..4 in order.
//  3. Full FIFO, out_ready=1 and push on the same cycle -> no drop, drop_count unchanged, fill_level stays 4.
//  4. in_valid with in_bytemask=0 -> no push, no drop; out_valid stays 0. Mask 32'hFFFF_FFFF -> out_len=32.
//  5. drop_count at 16'hFFFF plus another drop -> holds 16'hFFFF.
//     clear_stats with a same-cycle drop -> drop_count=1, overflow=1.
//  6. reset asserted mid-stream with 3 entries held -> out_valid=0 and fill_level=0 asynchronously;
//     after release the first push is output first.

Source files
------------

// File: rtl/msg_out_buffer_pkg.sv
// Shared message-parser definitions: widths, the stored message record and
// the bytemask popcount helper used wherever a byte length is needed.
package parser_pkg;

    localparam int OP_DATA_WIDTH = 256;
    localparam int OP_BM_WIDTH   = OP_DATA_WIDTH / 8;
    localparam int LEN_WIDTH     = $clog2(OP_BM_WIDTH) + 1;

    typedef struct packed {
        logic [OP_DATA_WIDTH-1:0] data;
        logic [OP_BM_WIDTH-1:0]   bytemask;
        logic [LEN_WIDTH-1:0]     len;
    } msg_t;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } head_state_t;

    function automatic logic [LEN_WIDTH-1:0] popcount(input logic [OP_BM_WIDTH-1:0] bytemask);
        logic [LEN_WIDTH-1:0] cnt;
        cnt = '0;
        for (int j = 0; j < OP_BM_WIDTH; j++) begin
            cnt = cnt + LEN_WIDTH'(bytemask[j]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/msg_out_buffer_if.sv
// Bundle of the parser-side input strobe, the valid/ready output port and
// the statistics signals of the output buffer.
interface msg_out_buffer_if #(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
);
    import parser_pkg::*;

    logic                       in_valid;
    logic [OP_DATA_WIDTH-1:0]   in_data;
    logic [OP_BM_WIDTH-1:0]     in_bytemask;
    logic                       out_valid;
    logic                       out_ready;
    logic [OP_DATA_WIDTH-1:0]   out_data;
    logic [OP_BM_WIDTH-1:0]     out_bytemask;
    logic [LEN_WIDTH-1:0]       out_len;
    logic [$clog2(DEPTH):0]     fill_level;
    logic                       overflow;
    logic [CNT_WIDTH-1:0]       drop_count;
    logic                       clear_stats;

    modport master (
        output in_valid, in_data, in_bytemask, out_ready, clear_stats,
        input  out_valid, out_data, out_bytemask, out_len, fill_level, overflow, drop_count
    );

    modport slave (
        input  in_valid, in_data, in_bytemask, out_ready, clear_stats,
        output out_valid, out_data, out_bytemask, out_len, fill_level, overflow, drop_count
    );

endinterface

// File: rtl/msg_sync_fifo.sv
// Message storage with wrap-around pointers and an entry count. A push and a
// pop in the same cycle are both honoured, including when the FIFO is full.
module msg_sync_fifo
    import parser_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  msg_t                   i_wdata,
    output msg_t                   o_next,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    msg_t               r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [PTR_W-1:0]   w_rptr_inc;
    logic [CNT_W-1:0]   r_count;

    // Storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The entry behind the current head, needed to reload the head register on a pop.
    assign w_rptr_inc = r_rptr + PTR_W'(1);
    assign o_next     = r_mem[w_rptr_inc];
    assign o_count    = r_count;
    assign o_full     = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/msg_out_buffer.sv
// Output stage of the message parser: absorbs one message per cycle, drops and
// counts messages when full, and presents the head message through a register.
module msg_out_buffer
    import parser_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    msg_out_buffer_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    head_state_t            r_state;
    head_state_t            w_state_next;
    msg_t                   r_head;
    msg_t                   w_head_next;
    msg_t                   w_in_msg;
    msg_t                   w_fifo_next;
    logic [CNT_W-1:0]       w_count;
    logic                   w_full;
    logic                   w_valid;
    logic                   w_req;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic                   r_overflow;
    logic [CNT_WIDTH-1:0]   r_drop_count;

    // The byte length is fixed when the message is accepted and travels with it.
    always_comb begin
        w_in_msg          = '0;
        w_in_msg.data     = bus.in_data;
        w_in_msg.bytemask = bus.in_bytemask;
        w_in_msg.len      = popcount(bus.in_bytemask);
    end

    assign w_req  = bus.in_valid && (bus.in_bytemask != '0);
    assign w_pop  = w_valid && bus.out_ready;
    assign w_push = w_req && (!w_full || w_pop);
    assign w_drop = w_req && w_full && !w_pop;

    msg_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_in_msg),
        .o_next  (w_fifo_next),
        .o_count (w_count),
        .o_full  (w_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY: if (w_push) w_state_next = HOLD;
            HOLD:  if (w_pop && (w_count == CNT_W'(1)) && !w_push) w_state_next = EMPTY;
            default: w_state_next = EMPTY;
        endcase
    end

    always_comb begin
        w_valid = (r_state == HOLD);
    end

    // Head mirrors the oldest stored entry, or zero whenever the FIFO is empty.
    always_comb begin
        w_head_next = r_head;
        if (w_pop) begin
            if (w_count > CNT_W'(1)) begin
                w_head_next = w_fifo_next;
            end else if (w_push) begin
                w_head_next = w_in_msg;
            end else begin
                w_head_next = '0;
            end
        end else if ((r_state == EMPTY) && w_push) begin
            w_head_next = w_in_msg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
        end else begin
            r_head <= w_head_next;
        end
    end

    // A clear takes priority but still records a drop from the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (bus.clear_stats) begin
            r_overflow   <= w_drop;
            r_drop_count <= w_drop ? CNT_WIDTH'(1) : '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (!(&r_drop_count)) begin
                r_drop_count <= r_drop_count + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.out_valid    = w_valid;
    assign bus.out_data     = r_head.data;
    assign bus.out_bytemask = r_head.bytemask;
    assign bus.out_len      = r_head.len;
    assign bus.fill_level   = w_count;
    assign bus.overflow     = r_overflow;
    assign bus.drop_count   = r_drop_count;

endmodule

// File: tb/tb_msg_out_buffer.sv
// Self-checking bench for msg_out_buffer: directed vector table, corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_msg_out_buffer;

    localparam int DEPTH     = 4;
    localparam int CNT_WIDTH = 16;
    localparam int NVEC      = 14;
    localparam int NRAND     = 1500;

    typedef struct {
        logic         valid;
        logic [255:0] data;
        logic [31:0]  mask;
        logic         ready;
        logic         clear;
        logic         exp_valid;
        int           exp_head;
        int           exp_len;
        int           exp_fill;
        logic         exp_ovf;
        int           exp_drop;
    } vec_t;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    vec_t         tbl [NVEC];
    logic [255:0] mq_data [$];
    logic [31:0]  mq_mask [$];
    int           m_drop;
    logic         m_ovf;
    logic [255:0] exp_d;
    logic [31:0]  exp_m;

    msg_out_buffer_if #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    msg_out_buffer #(
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference behaviour: queue of accepted messages plus drop statistics.
    task automatic modelStep(input logic v, input logic [255:0] d, input logic [31:0] m,
                             input logic r, input logic c);
        bit pop, req, drop;
        pop  = (mq_data.size() > 0) && r;
        req  = v && (m != 0);
        drop = req && (mq_data.size() == DEPTH) && !pop;
        if (pop) begin
            void'(mq_data.pop_front());
            void'(mq_mask.pop_front());
        end
        if (req && !drop) begin
            mq_data.push_back(d);
            mq_mask.push_back(m);
        end
        if (c) begin
            m_drop = drop ? 1 : 0;
            m_ovf  = drop;
        end else if (drop) begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
        end
    endtask

    task automatic modelReset();
        mq_data.delete();
        mq_mask.delete();
        m_drop = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic applyStimulus(input logic v, input logic [255:0] d, input logic [31:0] m,
                                 input logic r, input logic c);
        bus.in_valid    = v;
        bus.in_data     = d;
        bus.in_bytemask = m;
        bus.out_ready   = r;
        bus.clear_stats = c;
        @(posedge clk);
        modelStep(v, d, m, r, c);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [255:0] ed;
        logic [31:0]  em;
        ed = (mq_data.size() > 0) ? mq_data[0] : '0;
        em = (mq_mask.size() > 0) ? mq_mask[0] : '0;
        cmp({tag, ".valid"}, bus.out_valid,    mq_data.size() > 0);
        cmp({tag, ".data"},  bus.out_data,     ed);
        cmp({tag, ".mask"},  bus.out_bytemask, em);
        cmp({tag, ".len"},   bus.out_len,      $countones(em));
        cmp({tag, ".fill"},  bus.fill_level,   mq_data.size());
        cmp({tag, ".ovf"},   bus.overflow,     m_ovf);
        cmp({tag, ".drop"},  bus.drop_count,   m_drop);
    endtask

    task automatic setVec(input int i, input logic v, input logic [31:0] m, input logic r,
                          input logic c, input logic ev, input int eh, input int el,
                          input int ef, input logic eo, input int ed);
        logic [7:0] tag;
        tag = 8'(i);
        tbl[i].valid = v;  tbl[i].mask = m;  tbl[i].ready = r;  tbl[i].clear = c;
        tbl[i].data  = {8{tag, 8'h5A, 8'hC3, ~tag}};
        tbl[i].exp_valid = ev; tbl[i].exp_head = eh; tbl[i].exp_len = el;
        tbl[i].exp_fill  = ef; tbl[i].exp_ovf  = eo; tbl[i].exp_drop = ed;
    endtask

    function automatic logic [255:0] randData();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        logic [255:0] d;
        logic [31:0]  m;
        vectors     = 0;
        miscompares = 0;
        modelReset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_bytemask = '0;
        bus.out_ready = 1'b0; bus.clear_stats = 1'b0;

        // Directed table: single message, zero mask, fill to full, drop,
        // full push+pop, drain in order with a stats clear on the way.
        //     idx v  mask           r  c  ev hd  len fill ovf drop
        setVec( 0, 0, 32'h0,         1, 0, 0, -1,  0, 0,   0, 0);
        setVec( 1, 1, 32'h0000_00FF, 1, 0, 1,  1,  8, 1,   0, 0);
        setVec( 2, 0, 32'h0,         1, 0, 0, -1,  0, 0,   0, 0);
        setVec( 3, 1, 32'h0,         0, 0, 0, -1,  0, 0,   0, 0);
        setVec( 4, 1, 32'hFFFF_FFFF, 0, 0, 1,  4, 32, 1,   0, 0);
        setVec( 5, 1, 32'h0000_0001, 0, 0, 1,  4, 32, 2,   0, 0);
        setVec( 6, 1, 32'h0000_0003, 0, 0, 1,  4, 32, 3,   0, 0);
        setVec( 7, 1, 32'h0000_0007, 0, 0, 1,  4, 32, 4,   0, 0);
        setVec( 8, 1, 32'h0000_000F, 0, 0, 1,  4, 32, 4,   1, 1);
        setVec( 9, 1, 32'h0000_001F, 1, 0, 1,  5,  1, 4,   1, 1);
        setVec(10, 0, 32'h0,         1, 0, 1,  6,  2, 3,   1, 1);
        setVec(11, 0, 32'h0,         1, 1, 1,  7,  3, 2,   0, 0);
        setVec(12, 0, 32'h8000_0101, 1, 0, 1,  9,  5, 1,   0, 0);
        setVec(13, 0, 32'h0,         1, 0, 0, -1,  0, 0,   0, 0);
        tbl[1].data = 256'h0807_0605_0403_0201;

        repeat (2) @(posedge clk);
        #1;
        cmp("rst.valid", bus.out_valid,    0);
        cmp("rst.data",  bus.out_data,     0);
        cmp("rst.mask",  bus.out_bytemask, 0);
        cmp("rst.len",   bus.out_len,      0);
        cmp("rst.fill",  bus.fill_level,   0);
        cmp("rst.ovf",   bus.overflow,     0);
        cmp("rst.drop",  bus.drop_count,   0);
        #3 reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(tbl[i].valid, tbl[i].data, tbl[i].mask, tbl[i].ready, tbl[i].clear);
            exp_d = (tbl[i].exp_head < 0) ? '0 : tbl[tbl[i].exp_head].data;
            exp_m = (tbl[i].exp_head < 0) ? '0 : tbl[tbl[i].exp_head].mask;
            cmp($sformatf("vec%0d.valid", i), bus.out_valid,    tbl[i].exp_valid);
            cmp($sformatf("vec%0d.data", i),  bus.out_data,     exp_d);
            cmp($sformatf("vec%0d.mask", i),  bus.out_bytemask, exp_m);
            cmp($sformatf("vec%0d.len", i),   bus.out_len,      tbl[i].exp_len);
            cmp($sformatf("vec%0d.fill", i),  bus.fill_level,   tbl[i].exp_fill);
            cmp($sformatf("vec%0d.ovf", i),   bus.overflow,     tbl[i].exp_ovf);
            cmp($sformatf("vec%0d.drop", i),  bus.drop_count,   tbl[i].exp_drop);
        end

        // Saturating drop counter: fill, then 65535 drops, then one more.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, randData(), 32'h0000_0F0F, 1'b0, 1'b0);
        for (int i = 0; i < 65535; i++) applyStimulus(1'b1, 256'h1, 32'h1, 1'b0, 1'b0);
        cmp("sat.drop_max", bus.drop_count, 16'hFFFF);
        applyStimulus(1'b1, 256'h2, 32'h1, 1'b0, 1'b0);
        cmp("sat.drop_hold", bus.drop_count, 16'hFFFF);
        cmp("sat.fill",      bus.fill_level, 4);
        checkOutput("sat");

        applyStimulus(1'b1, 256'h3, 32'h1, 1'b0, 1'b1);
        cmp("clrdrop.drop", bus.drop_count, 1);
        cmp("clrdrop.ovf",  bus.overflow,   1);

        applyStimulus(1'b1, 256'h4, 32'h3, 1'b1, 1'b0);
        cmp("fullpp.fill", bus.fill_level, 4);
        cmp("fullpp.drop", bus.drop_count, 1);
        checkOutput("fullpp");

        // Asynchronous reset with entries held, then a fresh message comes out first.
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        cmp("prerst.fill", bus.fill_level, 3);
        #3 reset = 1'b1;
        #1;
        cmp("arst.valid", bus.out_valid,  0);
        cmp("arst.fill",  bus.fill_level, 0);
        cmp("arst.data",  bus.out_data,   0);
        modelReset();
        #2 reset = 1'b0;
        d = 256'hDEAD_BEEF_0123_4567;
        applyStimulus(1'b1, d, 32'h0000_00F0, 1'b0, 1'b0);
        cmp("postrst.data", bus.out_data, d);
        cmp("postrst.len",  bus.out_len,  4);
        checkOutput("postrst");

        // Randomized traffic; ready bias shifts midway to exercise both full and drained regimes.
        for (int i = 0; i < NRAND; i++) begin
            case ($urandom_range(0, 9))
                0:       m = 32'h0;
                1:       m = 32'hFFFF_FFFF;
                default: m = $urandom;
            endcase
            applyStimulus($urandom_range(0, 9) < 7, randData(), m,
                          $urandom_range(0, 99) < ((i < NRAND/2) ? 30 : 65),
                          $urandom_range(0, 49) == 0);
            checkOutput("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
